// File: rtl/popcount_pkg.sv
// rtl/popcount_pkg.sv - shared types and constants for the byte-serial popcount sequencer
//
// Purpose : FSM state encoding, datapath chunk width and the result-width helper
//           used by popcount_seq_ctrl and popcount8_unit.
// Ports   : none (package)

package popcount_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the shared popcount datapath; one chunk is counted per cycle.
    localparam int CHUNK_W = 8;

    // Bits needed to hold a count of 0..word_w set bits.
    function automatic int cnt_w(input int word_w);
        return $clog2(word_w + 1);
    endfunction

endpackage

// File: rtl/popcount8_unit.sv
// rtl/popcount8_unit.sv - combinational 8-bit population count from adder bit cells
//
// Purpose : counts the set bits of one byte using a small carry-save tree of
//           full- and half-adder cells.
// Ports   : i_bits  [7:0]  byte to count
//           o_count [3:0]  number of set bits (0..8)

module popcount8_unit
    import popcount_pkg::*;
(
    input  logic [CHUNK_W-1:0] i_bits,
    output logic [3:0]         o_count
);

    // Full adder cell: {carry, sum}
    function automatic logic [1:0] fa(input logic a, input logic b, input logic c);
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

    // Half adder cell: {carry, sum}
    function automatic logic [1:0] ha(input logic a, input logic b);
        return {a & b, a ^ b};
    endfunction

    // Stage 1: compress the eight weight-1 inputs into three weight-1 sums
    // and three weight-2 carries.
    logic [1:0] w_fa0;
    logic [1:0] w_fa1;
    logic [1:0] w_ha0;
    // Stage 2: reduce the weight-1 column to the result LSB plus one carry.
    logic [1:0] w_fa2;
    // Stage 3: reduce the four weight-2 bits.
    logic [1:0] w_fa3;
    logic [1:0] w_ha1;
    // Stage 4: the two weight-4 bits; their carry is the weight-8 result bit.
    logic [1:0] w_ha2;

    always_comb begin
        w_fa0 = fa(i_bits[0], i_bits[1], i_bits[2]);
        w_fa1 = fa(i_bits[3], i_bits[4], i_bits[5]);
        w_ha0 = ha(i_bits[6], i_bits[7]);

        w_fa2 = fa(w_fa0[0], w_fa1[0], w_ha0[0]);

        w_fa3 = fa(w_fa0[1], w_fa1[1], w_ha0[1]);
        w_ha1 = ha(w_fa3[0], w_fa2[1]);

        w_ha2 = ha(w_fa3[1], w_ha1[1]);

        o_count = {w_ha2[1], w_ha2[0], w_ha1[0], w_fa2[0]};
    end

endmodule

// File: rtl/popcount_seq_ctrl.sv
// rtl/popcount_seq_ctrl.sv - byte-serial popcount sequencer with valid/ready in and out
//
// Purpose : accepts a WORD_W-bit word, feeds it LSB byte first through a single
//           popcount8_unit over BEATS cycles, accumulates the byte counts and
//           presents the total until the consumer takes it.
// Ports   : CLK          clock, rising edge
//           ASYNCRESETN  asynchronous active-low reset
//           I_valid      input word valid
//           I_ready      block accepts a word this cycle
//           I_data       word to count [WORD_W-1:0]
//           O_valid      result valid
//           O_ready      consumer accepts result
//           O_count      set-bit count of the accepted word [CNT_W-1:0]
//           busy         high while the datapath is running
// WORD_W must be a multiple of 8 in the range 8..256.

module popcount_seq_ctrl
    import popcount_pkg::*;
#(
    parameter  int WORD_W = 32,
    localparam int CNT_W  = cnt_w(WORD_W)
) (
    input  logic              CLK,
    input  logic              ASYNCRESETN,
    input  logic              I_valid,
    output logic              I_ready,
    input  logic [WORD_W-1:0] I_data,
    output logic              O_valid,
    input  logic              O_ready,
    output logic [CNT_W-1:0]  O_count,
    output logic              busy
);

    localparam int BEATS  = WORD_W / CHUNK_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    state_t              r_state;
    logic [WORD_W-1:0]   r_shreg;
    logic [CNT_W-1:0]    r_acc;
    logic [BEAT_W-1:0]   r_beat;
    logic                r_o_valid;
    logic                r_busy;

    logic [3:0]          w_pc;
    logic                w_in_ready;

    popcount8_unit u_pc8 (
        .i_bits  (r_shreg[CHUNK_W-1:0]),
        .o_count (w_pc)
    );

    // A word can be taken when idle, or in DONE on the same edge the result
    // is consumed, which gives BEATS+1 cycle throughput without a buffer.
    always_comb begin
        w_in_ready = 1'b0;
        if (ASYNCRESETN) begin
            w_in_ready = (r_state == IDLE) || ((r_state == DONE) && O_ready);
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            r_state   <= IDLE;
            r_shreg   <= '0;
            r_acc     <= '0;
            r_beat    <= '0;
            r_o_valid <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (I_valid) begin
                        r_shreg <= I_data;
                        r_acc   <= '0;
                        r_beat  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end

                RUN: begin
                    r_acc   <= r_acc + CNT_W'(w_pc);
                    r_shreg <= r_shreg >> CHUNK_W;
                    if (r_beat == LAST_BEAT) begin
                        // Hold beat on the final pass so it never leaves
                        // 0..BEATS-1; the next capture clears it.
                        r_busy    <= 1'b0;
                        r_o_valid <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_beat <= r_beat + BEAT_W'(1);
                    end
                end

                DONE: begin
                    if (O_ready) begin
                        r_o_valid <= 1'b0;
                        if (I_valid) begin
                            r_shreg <= I_data;
                            r_acc   <= '0;
                            r_beat  <= '0;
                            r_busy  <= 1'b1;
                            r_state <= RUN;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end

                default: begin
                    r_o_valid <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign I_ready = w_in_ready;
    assign O_valid = r_o_valid;
    assign O_count = r_acc;
    assign busy    = r_busy;

endmodule

// File: tb/tb_popcount_seq_ctrl.sv
// tb/tb_popcount_seq_ctrl.sv - self-checking bench for popcount_seq_ctrl

module tb_popcount_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // 32-bit instance
    logic        a_ivalid = 1'b0;
    logic        a_iready;
    logic [31:0] a_idata = '0;
    logic        a_ovalid;
    logic        a_oready = 1'b1;
    logic [5:0]  a_ocount;
    logic        a_busy;

    // 8-bit instance
    logic        b_ivalid = 1'b0;
    logic        b_iready;
    logic [7:0]  b_idata = '0;
    logic        b_ovalid;
    logic        b_oready = 1'b1;
    logic [3:0]  b_ocount;
    logic        b_busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    popcount_seq_ctrl #(.WORD_W(32)) dut_a (
        .CLK         (clk),
        .ASYNCRESETN (rst_n),
        .I_valid     (a_ivalid),
        .I_ready     (a_iready),
        .I_data      (a_idata),
        .O_valid     (a_ovalid),
        .O_ready     (a_oready),
        .O_count     (a_ocount),
        .busy        (a_busy)
    );

    popcount_seq_ctrl #(.WORD_W(8)) dut_b (
        .CLK         (clk),
        .ASYNCRESETN (rst_n),
        .I_valid     (b_ivalid),
        .I_ready     (b_iready),
        .I_data      (b_idata),
        .O_valid     (b_ovalid),
        .O_ready     (b_oready),
        .O_count     (b_ocount),
        .busy        (b_busy)
    );

    // Offer d on dut_a and return once it has been taken on a rising edge.
    task automatic send_a(input logic [31:0] d, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        a_ivalid = 1'b1;
        a_idata  = d;
        #1;
        for (int i = 0; i < 30; i++) begin
            if (a_iready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        a_ivalid = 1'b0;
    endtask

    // Wait for a result on dut_a (O_ready assumed high); lat counts negedges.
    task automatic recv_a(output logic [5:0] cnt, output int lat, output bit ok);
        ok  = 1'b0;
        lat = 0;
        cnt = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            lat++;
            if (a_ovalid) begin
                cnt = a_ocount;
                ok  = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (a_ovalid !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid: got %b expected 0", a_ovalid); end
        n_checks++;
        if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
        n_checks++;
        if (a_ocount !== 6'd0) begin n_fail++; $display("FAIL reset_o_count: got %0d expected 0", a_ocount); end
        n_checks++;
        if (b_ovalid !== 1'b0) begin n_fail++; $display("FAIL reset_b_o_valid: got %b expected 0", b_ovalid); end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (a_iready !== 1'b1) begin n_fail++; $display("FAIL reset_i_ready: got %b expected 1", a_iready); end
        n_checks++;
        if (b_iready !== 1'b1) begin n_fail++; $display("FAIL reset_b_i_ready: got %b expected 1", b_iready); end
    endtask

    task automatic test_zero_latency();
        bit         ok;
        logic [5:0] cnt;
        int         lat;
        a_oready = 1'b1;
        send_a(32'h0000_0000, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL zero_accept: got no I_ready expected accept"); end
        @(negedge clk);
        #1;
        n_checks++;
        if (a_busy !== 1'b1 || a_iready !== 1'b0) begin
            n_fail++; $display("FAIL zero_run_flags: got busy=%b I_ready=%b expected busy=1 I_ready=0", a_busy, a_iready);
        end
        recv_a(cnt, lat, ok);
        n_checks++;
        if (!ok || cnt !== 6'd0) begin n_fail++; $display("FAIL zero_count: got %0d (seen=%0d) expected 0", cnt, ok); end
        n_checks++;
        if (lat != 4) begin n_fail++; $display("FAIL zero_latency: got %0d expected 4", lat); end
    endtask

    task automatic test_patterns();
        logic [31:0] words [3];
        int          exp   [3];
        bit          ok;
        logic [5:0]  cnt;
        int          lat;
        words[0] = 32'hFFFF_FFFF; exp[0] = 32;
        words[1] = 32'h8000_0001; exp[1] = 2;
        words[2] = 32'hF0F0_00FF; exp[2] = 16;
        a_oready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send_a(words[k], ok);
            recv_a(cnt, lat, ok);
            n_checks++;
            if (!ok || cnt !== exp[k][5:0]) begin
                n_fail++; $display("FAIL pattern_count[%0d]: got %0d expected %0d", k, cnt, exp[k]);
            end
            n_checks++;
            if (lat != 5) begin n_fail++; $display("FAIL pattern_latency[%0d]: got %0d expected 5", k, lat); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] tbl [4];
        int          exp [4];
        int          acc_cyc [4];
        int          si = 0;
        int          ri = 0;
        bit          took;
        tbl[0] = 32'h0000_0001; exp[0] = 1;
        tbl[1] = 32'h1234_5678; exp[1] = 13;
        tbl[2] = 32'hAAAA_5555; exp[2] = 16;
        tbl[3] = 32'h7FFF_FFFF; exp[3] = 31;
        a_oready = 1'b1;
        @(negedge clk);
        a_ivalid = 1'b1;
        a_idata  = tbl[0];
        for (int c = 0; c < 60 && ri < 4; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            took = a_ivalid && a_iready;
            if (took) acc_cyc[si] = c;
            if (a_ovalid && ri < 4) begin
                n_checks++;
                if (a_ocount !== exp[ri][5:0]) begin
                    n_fail++; $display("FAIL b2b_count[%0d]: got %0d expected %0d", ri, a_ocount, exp[ri]);
                end
                ri++;
            end
            @(posedge clk);
            #1;
            if (took) begin
                si++;
                if (si < 4) a_idata = tbl[si];
                else        a_ivalid = 1'b0;
            end
        end
        a_ivalid = 1'b0;
        n_checks++;
        if (si != 4 || ri != 4) begin
            n_fail++; $display("FAIL b2b_complete: got sent=%0d results=%0d expected 4/4", si, ri);
        end else begin
            for (int k = 1; k < 4; k++) begin
                n_checks++;
                if (acc_cyc[k] - acc_cyc[k-1] != 5) begin
                    n_fail++; $display("FAIL b2b_interval[%0d]: got %0d expected 5", k, acc_cyc[k] - acc_cyc[k-1]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit seen = 1'b0;
        a_oready = 1'b0;
        send_a(32'hF0F0_00FF, ok);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (a_ovalid) begin seen = 1'b1; break; end
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL bp_done: got O_valid=0 expected 1"); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a_ivalid = 1'b1;
            a_idata  = 32'h0000_0003;
            #1;
            n_checks++;
            if (a_ovalid !== 1'b1 || a_ocount !== 6'd16 || a_iready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got O_valid=%b O_count=%0d I_ready=%b expected 1/16/0",
                         i, a_ovalid, a_ocount, a_iready);
            end
        end
        @(negedge clk);
        a_ivalid = 1'b0;
        a_oready = 1'b1;
        #1;
        n_checks++;
        if (a_ovalid !== 1'b1 || a_iready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release: got O_valid=%b I_ready=%b expected 1/1", a_ovalid, a_iready);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (a_ovalid !== 1'b0 || a_busy !== 1'b0) begin
            n_fail++; $display("FAIL bp_single: got O_valid=%b busy=%b expected 0/0", a_ovalid, a_busy);
        end
    endtask

    task automatic test_async_reset();
        bit         ok;
        logic [5:0] cnt;
        int         lat;
        a_oready = 1'b1;
        send_a(32'hFFFF_FFFF, ok);
        @(posedge clk);
        @(posedge clk);
        #3;
        n_checks++;
        if (a_busy !== 1'b1) begin n_fail++; $display("FAIL arst_pre_busy: got %b expected 1", a_busy); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (a_busy !== 1'b0 || a_ovalid !== 1'b0 || a_ocount !== 6'd0) begin
            n_fail++; $display("FAIL arst_clear: got busy=%b O_valid=%b O_count=%0d expected 0/0/0",
                               a_busy, a_ovalid, a_ocount);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (a_iready !== 1'b1 || a_busy !== 1'b0) begin
            n_fail++; $display("FAIL arst_release: got I_ready=%b busy=%b expected 1/0", a_iready, a_busy);
        end
        send_a(32'h8000_0001, ok);
        recv_a(cnt, lat, ok);
        n_checks++;
        if (!ok || cnt !== 6'd2) begin n_fail++; $display("FAIL arst_next_count: got %0d expected 2", cnt); end
    endtask

    task automatic test_random_a();
        localparam int N = 3000;
        logic [5:0] q [$];
        logic [5:0] e;
        int  sent = 0;
        int  got  = 0;
        bit  took, gave;
        a_ivalid = 1'b0;
        for (int c = 0; c < 40000 && got < N; c++) begin
            @(negedge clk);
            if (!a_ivalid && sent < N && $urandom_range(0, 2) != 0) begin
                a_ivalid = 1'b1;
                case ($urandom_range(0, 7))
                    0:       a_idata = 32'hFFFF_FFFF;
                    1:       a_idata = 32'h0000_0000;
                    default: a_idata = $urandom;
                endcase
            end else if (!a_ivalid) begin
                a_idata = $urandom;
            end
            a_oready = ($urandom_range(0, 3) != 0);
            #1;
            took = a_ivalid && a_iready;
            gave = a_ovalid && a_oready;
            if (gave) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL rand32_spurious: got result %0d expected none", a_ocount);
                end else begin
                    e = q.pop_front();
                    if (a_ocount !== e) begin
                        n_fail++; $display("FAIL rand32_count[%0d]: got %0d expected %0d", got, a_ocount, e);
                    end
                end
                got++;
            end
            if (took) begin
                q.push_back(6'($countones(a_idata)));
                sent++;
            end
            @(posedge clk);
            #1;
            if (took) a_ivalid = 1'b0;
        end
        a_ivalid = 1'b0;
        a_oready = 1'b1;
        n_checks++;
        if (got != N) begin n_fail++; $display("FAIL rand32_complete: got %0d expected %0d", got, N); end
    endtask

    task automatic test_random_b();
        localparam int N = 3000;
        logic [3:0] q [$];
        logic [3:0] e;
        int  sent = 0;
        int  got  = 0;
        bit  took, gave;
        b_ivalid = 1'b0;
        for (int c = 0; c < 30000 && got < N; c++) begin
            @(negedge clk);
            if (!b_ivalid && sent < N && $urandom_range(0, 2) != 0) begin
                b_ivalid = 1'b1;
                case ($urandom_range(0, 7))
                    0:       b_idata = 8'hFF;
                    1:       b_idata = 8'h00;
                    default: b_idata = 8'($urandom_range(0, 255));
                endcase
            end else if (!b_ivalid) begin
                b_idata = 8'($urandom_range(0, 255));
            end
            b_oready = ($urandom_range(0, 3) != 0);
            #1;
            took = b_ivalid && b_iready;
            gave = b_ovalid && b_oready;
            if (gave) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL rand8_spurious: got result %0d expected none", b_ocount);
                end else begin
                    e = q.pop_front();
                    if (b_ocount !== e) begin
                        n_fail++; $display("FAIL rand8_count[%0d]: got %0d expected %0d", got, b_ocount, e);
                    end
                end
                got++;
            end
            if (took) begin
                q.push_back(4'($countones(b_idata)));
                sent++;
            end
            @(posedge clk);
            #1;
            if (took) b_ivalid = 1'b0;
        end
        b_ivalid = 1'b0;
        b_oready = 1'b1;
        n_checks++;
        if (got != N) begin n_fail++; $display("FAIL rand8_complete: got %0d expected %0d", got, N); end
    endtask

    initial begin
        test_reset();
        test_zero_latency();
        test_patterns();
        test_back_to_back();
        test_backpressure();
        test_async_reset();
        test_random_a();
        test_random_b();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got simulation timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
